writeback_stage: RTL and testbench

Final stage of the 5-stage pipelined CPU, directly downstream of the memory stage. It consumes the registered MEM/WB bundle and extracts and extends load data, including the LWL/LWR merge. It selects the final write-back value (ALU, memory, CP0 or HI/LO) and drives the register-file write port. It also owns the HI/LO architectural registers, a retired-instruction counter, and the `wb_allowin` handshake back to the memory stage.

---
 rtl/writeback_stage.sv | 124 ++++++++++++
 tb/tb_writeback_stage.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_stage.sv
// writeback_stage: final pipeline stage - load extract/merge, write-back select, HI/LO, retire counter.
// Optional WB_TRACE_EN adds registered debug_wb_* trace outputs.
module writeback_stage #(
    parameter int RETIRE_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                valid_MEM_WB,
    input  logic                mem_go,
    input  logic                wb_stall,
    input  logic                MemToReg_MEM_WB,
    input  logic [3:0]          RegWrite_MEM_WB,
    input  logic [4:0]          RegWaddr_MEM_WB,
    input  logic [1:0]          MFHL_MEM_WB,
    input  logic                LB_MEM_WB,
    input  logic                LBU_MEM_WB,
    input  logic                LH_MEM_WB,
    input  logic                LHU_MEM_WB,
    input  logic [1:0]          LW_MEM_WB,
    input  logic [31:0]         ALUResult_MEM_WB,
    input  logic [31:0]         RegRdata2_MEM_WB,
    input  logic [31:0]         MemRdata_MEM_WB,
    input  logic [31:0]         cp0Rdata_MEM_WB,
    input  logic [31:0]         PC_MEM_WB,
    input  logic                mfc0_MEM_WB,
    input  logic [1:0]          HILO_we,
    input  logic [31:0]         HI_in,
    input  logic [31:0]         LO_in,
    output logic                wb_allowin,
    output logic [3:0]          RegWen_WB,
    output logic [4:0]          RegWaddr_WB,
    output logic [31:0]         RegWdata_WB,
    output logic [31:0]         Bypass_WB,
    output logic [31:0]         HI_out,
    output logic [31:0]         LO_out,
`ifdef WB_TRACE_EN
    output logic [31:0]         debug_wb_pc,
    output logic [3:0]          debug_wb_rf_wen,
    output logic [4:0]          debug_wb_rf_wnum,
    output logic [31:0]         debug_wb_rf_wdata,
`endif
    output logic [RETIRE_W-1:0] retire_cnt
);
    logic        valid_WB;
    logic        retire;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] m;
    logic [31:0] r;
    logic [4:0]  sh;
    logic [31:0] ms;
    logic [31:0] mh;
    logic [31:0] lwl;
    logic [31:0] lwr;
    logic [31:0] load;

    assign m          = MemRdata_MEM_WB;
    assign r          = RegRdata2_MEM_WB;
    assign sh         = {ALUResult_MEM_WB[1:0], 3'b000};
    assign retire     = valid_WB && !wb_stall;
    assign wb_allowin = !valid_WB || !wb_stall;
    assign RegWen_WB  = RegWrite_MEM_WB & {4{retire}};
    assign RegWaddr_WB = RegWaddr_MEM_WB;
    assign Bypass_WB  = RegWdata_WB;
    assign HI_out     = hi;
    assign LO_out     = lo;
    assign ms         = m >> sh;
    assign mh         = m >> {ALUResult_MEM_WB[1], 4'b0000};
    // Unaligned merges: memory bytes land at the top (LWL) or bottom (LWR), the rest keeps rt.
    assign lwl        = (m << (5'd24 - sh)) | (r & (32'h00FF_FFFF >> sh));
    assign lwr        = (m >> sh) | (r & ~(32'hFFFF_FFFF >> sh));

    always_comb begin
        load = LB_MEM_WB       ? {{24{ms[7]}}, ms[7:0]} :
               LBU_MEM_WB      ? {24'b0, ms[7:0]} :
               LH_MEM_WB       ? {{16{mh[15]}}, mh[15:0]} :
               LHU_MEM_WB      ? {16'b0, mh[15:0]} :
               LW_MEM_WB == 2'b10 ? lwl :
               LW_MEM_WB == 2'b01 ? lwr : m;
        RegWdata_WB = mfc0_MEM_WB          ? cp0Rdata_MEM_WB :
                      MFHL_MEM_WB == 2'b10 ? hi :
                      MFHL_MEM_WB == 2'b01 ? lo :
                      MemToReg_MEM_WB      ? load : ALUResult_MEM_WB;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_WB   <= 1'b0;
            hi         <= '0;
            lo         <= '0;
            retire_cnt <= '0;
        end else begin
            if (mem_go && wb_allowin)
                valid_WB <= valid_MEM_WB;
            else if (retire)
                valid_WB <= 1'b0;
            if (retire)
                retire_cnt <= retire_cnt + RETIRE_W'(1);
            if (HILO_we[1])
                hi <= HI_in;
            if (HILO_we[0])
                lo <= LO_in;
        end
    end

`ifdef WB_TRACE_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            debug_wb_pc       <= '0;
            debug_wb_rf_wen   <= '0;
            debug_wb_rf_wnum  <= '0;
            debug_wb_rf_wdata <= '0;
        end else begin
            debug_wb_pc       <= PC_MEM_WB;
            debug_wb_rf_wen   <= RegWen_WB;
            debug_wb_rf_wnum  <= RegWaddr_WB;
            debug_wb_rf_wdata <= RegWdata_WB;
        end
    end
`else
    logic unused_pc;
    assign unused_pc = ^PC_MEM_WB;
`endif
endmodule

// File: tb/tb_writeback_stage.sv
// tb_writeback_stage: directed vectors with literal checks plus a per-cycle behavioural model.
// Build with WB_TRACE_EN defined to also check the debug trace outputs.
module tb_writeback_stage;
    logic        clk = 0;
    logic        rst = 1;
    logic        valid_MEM_WB = 0, mem_go = 0, wb_stall = 0, MemToReg_MEM_WB = 0;
    logic [3:0]  RegWrite_MEM_WB = 0;
    logic [4:0]  RegWaddr_MEM_WB = 0;
    logic [1:0]  MFHL_MEM_WB = 0;
    logic        LB_MEM_WB = 0, LBU_MEM_WB = 0, LH_MEM_WB = 0, LHU_MEM_WB = 0;
    logic [1:0]  LW_MEM_WB = 0;
    logic [31:0] ALUResult_MEM_WB = 0, RegRdata2_MEM_WB = 0, MemRdata_MEM_WB = 0;
    logic [31:0] cp0Rdata_MEM_WB = 0, PC_MEM_WB = 0;
    logic        mfc0_MEM_WB = 0;
    logic [1:0]  HILO_we = 0;
    logic [31:0] HI_in = 0, LO_in = 0;
    logic        wb_allowin;
    logic [3:0]  RegWen_WB;
    logic [4:0]  RegWaddr_WB;
    logic [31:0] RegWdata_WB, Bypass_WB, HI_out, LO_out;
    logic [3:0]  retire_cnt;
`ifdef WB_TRACE_EN
    logic [31:0] debug_wb_pc, debug_wb_rf_wdata;
    logic [3:0]  debug_wb_rf_wen;
    logic [4:0]  debug_wb_rf_wnum;
`endif

    int checks = 0;
    int failures = 0;

    writeback_stage #(.RETIRE_W(4)) dut (
        .clk(clk), .rst(rst), .valid_MEM_WB(valid_MEM_WB), .mem_go(mem_go), .wb_stall(wb_stall),
        .MemToReg_MEM_WB(MemToReg_MEM_WB), .RegWrite_MEM_WB(RegWrite_MEM_WB),
        .RegWaddr_MEM_WB(RegWaddr_MEM_WB), .MFHL_MEM_WB(MFHL_MEM_WB), .LB_MEM_WB(LB_MEM_WB),
        .LBU_MEM_WB(LBU_MEM_WB), .LH_MEM_WB(LH_MEM_WB), .LHU_MEM_WB(LHU_MEM_WB),
        .LW_MEM_WB(LW_MEM_WB), .ALUResult_MEM_WB(ALUResult_MEM_WB),
        .RegRdata2_MEM_WB(RegRdata2_MEM_WB), .MemRdata_MEM_WB(MemRdata_MEM_WB),
        .cp0Rdata_MEM_WB(cp0Rdata_MEM_WB), .PC_MEM_WB(PC_MEM_WB), .mfc0_MEM_WB(mfc0_MEM_WB),
        .HILO_we(HILO_we), .HI_in(HI_in), .LO_in(LO_in), .wb_allowin(wb_allowin),
        .RegWen_WB(RegWen_WB), .RegWaddr_WB(RegWaddr_WB), .RegWdata_WB(RegWdata_WB),
        .Bypass_WB(Bypass_WB), .HI_out(HI_out), .LO_out(LO_out),
`ifdef WB_TRACE_EN
        .debug_wb_pc(debug_wb_pc), .debug_wb_rf_wen(debug_wb_rf_wen),
        .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata),
`endif
        .retire_cnt(retire_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%08h expected=%08h", name, got, exp);
        end
    endtask

    // Load value from byte lanes, independent of any shifter formulation.
    function automatic logic [31:0] load_val(input logic [1:0] a, input logic [31:0] m, input logic [31:0] r);
        logic [7:0] mb [4];
        logic [7:0] rb [4];
        logic [7:0] ob [4];
        logic [15:0] h;
        for (int i = 0; i < 4; i++) begin
            mb[i] = m[8*i +: 8];
            rb[i] = r[8*i +: 8];
        end
        h = a[1] ? {mb[3], mb[2]} : {mb[1], mb[0]};
        if (LB_MEM_WB) return {{24{mb[a][7]}}, mb[a]};
        if (LBU_MEM_WB) return {24'b0, mb[a]};
        if (LH_MEM_WB) return {{16{h[15]}}, h};
        if (LHU_MEM_WB) return {16'b0, h};
        if (LW_MEM_WB == 2'b10) begin
            for (int i = 0; i < 4; i++) ob[i] = (i >= 3 - a) ? mb[i - (3 - a)] : rb[i];
            return {ob[3], ob[2], ob[1], ob[0]};
        end
        if (LW_MEM_WB == 2'b01) begin
            for (int i = 0; i < 4; i++) ob[i] = (i <= 3 - a) ? mb[i + a] : rb[i];
            return {ob[3], ob[2], ob[1], ob[0]};
        end
        return m;
    endfunction

    bit          m_valid = 0;
    int          m_cnt = 0;
    logic [31:0] m_hi = 0, m_lo = 0;
    logic [31:0] p_pc = 0, p_wdata = 0;
    logic [3:0]  p_wen = 0;
    logic [4:0]  p_wnum = 0;

    always @(negedge clk) begin
        bit          ret;
        logic [3:0]  e_wen;
        logic [31:0] e_data;
        ret = m_valid && !wb_stall;
        e_wen = ret ? RegWrite_MEM_WB : 4'h0;
        e_data = mfc0_MEM_WB ? cp0Rdata_MEM_WB :
                 MFHL_MEM_WB == 2'b10 ? m_hi :
                 MFHL_MEM_WB == 2'b01 ? m_lo :
                 MemToReg_MEM_WB ? load_val(ALUResult_MEM_WB[1:0], MemRdata_MEM_WB, RegRdata2_MEM_WB) :
                 ALUResult_MEM_WB;
        if (!rst) begin
            check("allowin", {31'b0, wb_allowin}, {31'b0, !m_valid || !wb_stall});
            check("wen", {28'b0, RegWen_WB}, {28'b0, e_wen});
            check("waddr", {27'b0, RegWaddr_WB}, {27'b0, RegWaddr_MEM_WB});
            check("wdata", RegWdata_WB, e_data);
            check("bypass", Bypass_WB, e_data);
            check("hi", HI_out, m_hi);
            check("lo", LO_out, m_lo);
            check("cnt", {28'b0, retire_cnt}, m_cnt);
`ifdef WB_TRACE_EN
            check("dbg_pc", debug_wb_pc, p_pc);
            check("dbg_wen", {28'b0, debug_wb_rf_wen}, {28'b0, p_wen});
            check("dbg_wnum", {27'b0, debug_wb_rf_wnum}, {27'b0, p_wnum});
            check("dbg_wdata", debug_wb_rf_wdata, p_wdata);
`endif
        end
        if (rst) begin
            m_valid = 0; m_cnt = 0; m_hi = 0; m_lo = 0;
            p_pc = 0; p_wen = 0; p_wnum = 0; p_wdata = 0;
        end else begin
            p_pc = PC_MEM_WB; p_wen = e_wen; p_wnum = RegWaddr_MEM_WB; p_wdata = e_data;
            if (mem_go && (!m_valid || !wb_stall)) m_valid = valid_MEM_WB;
            else if (ret) m_valid = 0;
            if (ret) m_cnt = (m_cnt + 1) % 16;
            if (HILO_we[1]) m_hi = HI_in;
            if (HILO_we[0]) m_lo = LO_in;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue();
        valid_MEM_WB = 1; mem_go = 1;
        step();
        mem_go = 0; valid_MEM_WB = 0;
    endtask

    task automatic load_setup(input logic [1:0] lw, input logic [1:0] a, input logic [31:0] m, input logic [31:0] r);
        {LB_MEM_WB, LBU_MEM_WB, LH_MEM_WB, LHU_MEM_WB, mfc0_MEM_WB, MFHL_MEM_WB} = 0;
        MemToReg_MEM_WB = 1; RegWrite_MEM_WB = 4'hF; LW_MEM_WB = lw;
        ALUResult_MEM_WB = {30'h1000, a}; MemRdata_MEM_WB = m; RegRdata2_MEM_WB = r;
    endtask

    initial begin
        logic [3:0] c0;
        step(); step();
        rst = 0;
        @(negedge clk);
        check("rst_allowin", {31'b0, wb_allowin}, 1);
        check("rst_wen", {28'b0, RegWen_WB}, 0);
        check("rst_cnt", {28'b0, retire_cnt}, 0);
        check("rst_hi", HI_out, 0);
        step();
        load_setup(2'b00, 2'd3, 32'h80FF1234, 32'h0); LB_MEM_WB = 1; RegWaddr_MEM_WB = 5'd3; PC_MEM_WB = 32'hBFC00010;
        issue(); @(negedge clk);
        check("lb", RegWdata_WB, 32'hFFFFFF80);
        check("lb_wen", {28'b0, RegWen_WB}, 32'hF);
        step();
        load_setup(2'b00, 2'd3, 32'h80FF1234, 32'h0); LBU_MEM_WB = 1;
        issue(); @(negedge clk);
        check("lbu", RegWdata_WB, 32'h00000080);
        step();
        load_setup(2'b10, 2'd1, 32'hAABBCCDD, 32'h11223344);
        issue(); @(negedge clk);
        check("lwl_a1", RegWdata_WB, 32'hCCDD3344);
        step();
        load_setup(2'b01, 2'd1, 32'hAABBCCDD, 32'h11223344);
        issue(); @(negedge clk);
        check("lwr_a1", RegWdata_WB, 32'h11AABBCC);
        step();
        for (int i = 0; i < 4; i++) begin
            load_setup(2'b10, i[1:0], 32'hAABBCCDD, 32'h11223344); issue(); step();
            load_setup(2'b01, i[1:0], 32'hAABBCCDD, 32'h11223344); issue(); step();
            load_setup(2'b00, i[1:0], 32'h8091A2B3, 32'h0); LH_MEM_WB = 1; issue(); step();
            load_setup(2'b00, i[1:0], 32'h8091A2B3, 32'h0); LHU_MEM_WB = 1; issue(); step();
        end
        load_setup(2'b00, 2'd0, 32'h0, 32'h0); MemToReg_MEM_WB = 0; MFHL_MEM_WB = 2'b10;
        issue();
        HILO_we = 2'b10; HI_in = 32'h12345678; valid_MEM_WB = 1; mem_go = 1;
        @(negedge clk);
        check("mfhi_old", RegWdata_WB, 32'h0);
        step();
        HILO_we = 0; mem_go = 0; valid_MEM_WB = 0;
        @(negedge clk);
        check("mfhi_new", RegWdata_WB, 32'h12345678);
        step();
        HILO_we = 2'b01; LO_in = 32'hCAFE0001; step(); HILO_we = 0;
        MFHL_MEM_WB = 2'b01; issue(); step();
        MFHL_MEM_WB = 0; ALUResult_MEM_WB = 32'h00000055; RegWaddr_MEM_WB = 5'd7;
        issue();
        wb_stall = 1;
        c0 = retire_cnt;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_wen", {28'b0, RegWen_WB}, 0);
            check("stall_allowin", {31'b0, wb_allowin}, 0);
            step();
        end
        wb_stall = 0;
        @(negedge clk);
        check("stall_release_wen", {28'b0, RegWen_WB}, 32'hF);
        step();
        @(negedge clk);
        check("stall_cnt", {28'b0, retire_cnt}, {28'b0, c0 + 4'd1});
        check("stall_single", {28'b0, RegWen_WB}, 0);
        step();
        load_setup(2'b11, 2'd0, 32'h01020304, 32'h0); mfc0_MEM_WB = 1; cp0Rdata_MEM_WB = 32'hDEADBEEF;
        issue(); @(negedge clk);
        check("mfc0_prio", RegWdata_WB, 32'hDEADBEEF);
        step();
        mfc0_MEM_WB = 0;
        rst = 1; step(); rst = 0;
        valid_MEM_WB = 1; mem_go = 1;
        for (int i = 0; i < 17; i++) step();
        mem_go = 0; valid_MEM_WB = 0;
        step();
        @(negedge clk);
        check("wrap_cnt", {28'b0, retire_cnt}, 1);
        step();
        valid_MEM_WB = 1; mem_go = 1;
        step(); step();
        wb_stall = 1; mem_go = 0; valid_MEM_WB = 0;
        step();
        rst = 1; step(); rst = 0;
        wb_stall = 0;
        @(negedge clk);
        check("rst_mid_cnt", {28'b0, retire_cnt}, 0);
        check("rst_mid_allowin", {31'b0, wb_allowin}, 1);
        check("rst_mid_wen", {28'b0, RegWen_WB}, 0);
        step(); step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
